call_stack: RTL and testbench
=============================

# call_stack

Return-address stack for the 8-bit computer's program counter: on a call the current address is pushed; on a return the saved address is popped and presented, with a one-cycle load strobe, to the program counter's load inputs (`in` / `sel_in`). It is the supplier of load values to the program counter, sitting between the control sequencer and the counter.

## Interface
- `WIDTH`, 8, address/data width; matches the program counter width.
- `DEPTH`, 8, number of stack entries; power of two, at least 2.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `push`  in  1  push `push_data` this cycle.
- `pop`  in  1  pop top entry this cycle.
- `push_data`  in  WIDTH  value to push (return address from PC).
- `ret_addr`  out  WIDTH  popped value; wire to PC `in`.
- `ret_valid`  out  1  one-cycle strobe; wire to PC `sel_in`.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `err_clear`  in  1  clears sticky error flags.
- `overflow`  out  1  sticky: push refused while full.
- `underflow`  out  1  sticky: pop refused while empty.

## Operation
- Stack pointer `sp` equals `count`. A push writes `mem[sp]` and increments `sp`. A pop reads `mem[sp-1]` and decrements `sp`.
- The pop result is registered into `ret_addr`. `ret_valid` is high for exactly one cycle per accepted pop.
- `ret_addr` holds its last value while `ret_valid` is low.
- Push only, not full: write, `sp+1`.
- Push only, full: entry dropped, `sp` unchanged, `overflow` set.
- Pop only, not empty: `ret_addr <= mem[sp-1]`, `ret_valid <= 1`, `sp-1`.
- Pop only, empty: `ret_valid` stays 0, `ret_addr` unchanged, `underflow` set.
- Push and pop, not empty (this includes full): replace.
  - `ret_addr <= mem[sp-1]` (old top), `ret_valid <= 1`.
  - `mem[sp-1] <= push_data`, `sp` unchanged.
  - No flag is set.
- Push and pop, empty: bypass. `ret_addr <= push_data`, `ret_valid <= 1`, `sp` stays 0, no flag is set.
- `err_clear` clears both sticky flags. If an error event occurs in the same cycle as `err_clear`, the error wins and the flag is set.
- Reset:
  - `sp=0`, `empty=1`, `full=0`, `ret_addr=0`, `ret_valid=0`, `overflow=0`, `underflow=0`.
  - Memory contents are not cleared.
  - Reset has priority over `push`, `pop` and `err_clear` in the same cycle.
  - A `ret_valid` pending from the previous edge is dropped by reset.

## Timing
- Pop sampled at edge N: `ret_addr`/`ret_valid` are valid after edge N. The PC loads at edge N+1. `count` updates at edge N.
- Push sampled at edge N: entry is visible to a pop sampled at edge N+1 (back-to-back push then pop returns the pushed value).
- `empty`, `full` and `count` are combinational from `sp`, which is registered; they change only on clock edges.
- Sustained one operation per cycle; no stalls.

## Configuration
- `CALL_STACK_ERR_EN` defined:
  - Sticky `overflow`/`underflow` logic and `err_clear` are compiled in, as described above.
- `CALL_STACK_ERR_EN` not defined:
  - `overflow` and `underflow` are tied to 0.
  - `err_clear` is ignored.
  - Push/pop refusal behaviour is otherwise identical.
  - Port list is unchanged.

## Structure
- Package `call_stack_pkg` holds:
  - default `WIDTH`/`DEPTH`;
  - the pointer-width constant (`$clog2(DEPTH)+1`);
  - an operation-encoding enum for the `{push,pop}` decode: IDLE, PUSH, POP, REPLACE.
- Sub-module `stack_mem`:
  - DEPTH×WIDTH register file;
  - synchronous write port, asynchronous read port addressed by `sp-1`.
- `call_stack` owns the pointer, the decode, the output registers and the flags.

## Test plan
- Reset, then push 0x10, 0x20, 0x30, then pop ×3 on consecutive cycles -> `ret_addr` 0x30, 0x20, 0x10, each with a one-cycle `ret_valid`; `empty=1` afterwards.
- With DEPTH=4, push 0x01..0x04 -> `full=1`, `count=4`. Push 0x05 -> `overflow=1`, `count=4`. Pop -> returns 0x04.
- Pop on empty -> `ret_valid` stays 0, `underflow=1`. Assert `err_clear` -> `underflow=0`. Without `CALL_STACK_ERR_EN` -> both flags are always 0.
- Stack holds 0x40; push 0x55 and pop in the same cycle -> `ret_addr=0x40`, `count=1`. A later pop returns 0x55.
- Empty stack; push 0xAA and pop in the same cycle -> `ret_addr=0xAA`, `ret_valid=1`, `count=0`, no `underflow`.
- Push 0x11 and 0x22, then assert `reset` in the same cycle as a pop -> `count=0`, `ret_valid=0`, `ret_addr=0`.

Source files
------------

// File: rtl/call_stack_pkg.sv
// call_stack_pkg: default sizes, pointer width and {push,pop} operation encoding for call_stack
package call_stack_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int PTR_W = $clog2(DEPTH_DEF) + 1;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    POP     = 2'b01,
    PUSH    = 2'b10,
    REPLACE = 2'b11
  } op_e;
endpackage

// File: rtl/call_stack_mem.sv
// stack_mem: DEPTH x WIDTH register file, sync write (clk, we, waddr, wdata), async read (raddr -> rdata)
module stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_comb rdata = mem[raddr];
endmodule

// File: rtl/call_stack.sv
// call_stack: return-address stack feeding PC load (ret_addr/ret_valid); count/empty/full status; sticky overflow/underflow with err_clear when CALL_STACK_ERR_EN is defined
module call_stack
  import call_stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] ret_addr,
  output logic             ret_valid,
  output logic [PW-1:0]    count,
  output logic             empty,
  output logic             full,
  input  logic             err_clear,
  output logic             overflow,
  output logic             underflow
);
  logic [PW-1:0] sp, sp_dec;
  logic [WIDTH-1:0] top;
  op_e op;
  logic we, pop_ok, push_ok;
  always_comb begin
    op = op_e'({push, pop});
    sp_dec = sp - PW'(1);
    empty = sp == '0;
    full = sp == PW'(DEPTH);
    count = sp;
    push_ok = op == PUSH && !full;
    pop_ok = op == REPLACE || (op == POP && !empty);
    we = push_ok || (op == REPLACE && !empty);
  end
  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(op == REPLACE ? sp_dec[AW-1:0] : sp[AW-1:0]),
    .wdata(push_data),
    .raddr(sp_dec[AW-1:0]),
    .rdata(top)
  );
  always_ff @(posedge clk)
    if (reset) begin
      sp <= '0;
      ret_valid <= 1'b0;
      ret_addr <= '0;
    end else begin
      sp <= push_ok ? sp + PW'(1) : (op == POP && !empty) ? sp_dec : sp;
      ret_valid <= pop_ok;
      if (pop_ok) ret_addr <= empty ? push_data : top;
    end
`ifdef CALL_STACK_ERR_EN
  always_ff @(posedge clk)
    if (reset) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= (op == PUSH && full) || (overflow && !err_clear);
      underflow <= (op == POP && empty) || (underflow && !err_clear);
    end
`else
  logic unused_err_clear;
  always_comb begin
    unused_err_clear = err_clear;
    overflow = 1'b0;
    underflow = 1'b0;
  end
`endif
endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: directed plus random stimulus checked against a queue-based stack model
module tb_call_stack;
  localparam int D = 4;
  logic clk = 0, reset = 0, push = 0, pop = 0, err_clear = 0;
  logic [7:0] push_data = 0, ret_addr;
  logic ret_valid, empty, full, overflow, underflow;
  logic [2:0] count;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic [7:0] m_ra;
  logic m_rv, m_ovf, m_unf;
  call_stack #(.WIDTH(8), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
    .ret_addr(ret_addr), .ret_valid(ret_valid), .count(count), .empty(empty),
    .full(full), .err_clear(err_clear), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic p, input logic po, input logic [7:0] d,
                      input logic c = 1'b0, input logic r = 1'b0);
    logic eo, eu;
    push = p; pop = po; push_data = d; err_clear = c; reset = r;
    @(posedge clk);
    eo = 0; eu = 0;
    if (r) begin
      q.delete(); m_ra = 0; m_rv = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_rv = 0;
      if (p && po) begin
        m_rv = 1;
        if (q.size() == 0) m_ra = d;
        else begin m_ra = q[$]; q[$] = d; end
      end else if (p) begin
        if (q.size() < D) q.push_back(d); else eo = 1;
      end else if (po) begin
        if (q.size() > 0) begin m_ra = q.pop_back(); m_rv = 1; end else eu = 1;
      end
`ifdef CALL_STACK_ERR_EN
      m_ovf = eo || (m_ovf && !c);
      m_unf = eu || (m_unf && !c);
`else
      m_ovf = 0; m_unf = 0;
`endif
    end
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == D));
    chk("ret_valid", 32'(ret_valid), 32'(m_rv));
    chk("ret_addr", 32'(ret_addr), 32'(m_ra));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask
  initial begin
    step(0, 0, 0, 0, 1);
    step(1, 0, 8'h10); step(1, 0, 8'h20); step(1, 0, 8'h30);
    step(0, 1, 0); chk("lifo0", 32'(ret_addr), 32'h30);
    step(0, 1, 0); chk("lifo1", 32'(ret_addr), 32'h20);
    step(0, 1, 0); chk("lifo2", 32'(ret_addr), 32'h10);
    step(0, 0, 0); chk("strobe_drop", 32'(ret_valid), 0);
    for (int i = 1; i <= 4; i++) step(1, 0, 8'(i));
    chk("full_at4", 32'(full), 1);
    step(1, 0, 8'h05);
    step(0, 1, 0); chk("pop_after_ovf", 32'(ret_addr), 32'h04);
    step(1, 1, 8'h77);
    step(0, 0, 0, 1);
    repeat (3) step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 8'h40);
    step(1, 1, 8'h55); chk("replace_ret", 32'(ret_addr), 32'h40);
    step(0, 1, 0); chk("replace_new", 32'(ret_addr), 32'h55);
    step(1, 1, 8'hAA); chk("bypass", 32'(ret_addr), 32'hAA);
    step(1, 0, 8'h11); step(1, 0, 8'h22);
    step(0, 1, 0, 0, 1);
    step(1, 0, 8'h33); step(0, 1, 0);
    step(0, 0, 0, 0, 1); chk("reset_drops_strobe", 32'(ret_valid), 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), 8'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
